// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and the
// one-hot result record.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_result_t;

endpackage

// File: rtl/digit_cmp.sv
// Combinational compare of one DIGIT-bit slice pair. Flipping the slice MSB
// turns two's-complement ordering into plain unsigned (offset-binary) ordering.
module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] slice_a,
    input  logic [DIGIT-1:0] slice_b,
    input  logic             invert_msb,
    output logic             gt,
    output logic             lt
);

    logic [DIGIT-1:0] w_mask;
    logic [DIGIT-1:0] w_a;
    logic [DIGIT-1:0] w_b;

    always_comb begin
        w_mask            = '0;
        w_mask[DIGIT-1]   = invert_msb;
    end

    assign w_a = slice_a ^ w_mask;
    assign w_b = slice_b ^ w_mask;
    assign gt  = (w_a > w_b);
    assign lt  = (w_a < w_b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: scans captured operands MSB-first, DIGIT
// bits per cycle, and presents a registered one-hot eq/gt/lt result.
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    cmp_state_t       r_state;
    cmp_result_t      r_res;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;

    logic [DIGIT-1:0] w_slice_a;
    logic [DIGIT-1:0] w_slice_b;
    logic             w_invert;
    logic             w_gt;
    logic             w_lt;
    logic             w_found;
    logic             w_last;
    logic             w_capture;

    assign w_capture = (r_state == IDLE) && in_valid;
    assign w_found   = r_res.gt | r_res.lt;
    assign w_last    = (r_idx == '0);
    assign w_invert  = r_signed && (r_idx == IDXW'(NDIG - 1));

    always_comb begin
        w_slice_a = '0;
        w_slice_b = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_slice_a = r_a[k*DIGIT +: DIGIT];
                w_slice_b = r_b[k*DIGIT +: DIGIT];
            end
        end
    end

    digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .slice_a    (w_slice_a),
        .slice_b    (w_slice_b),
        .invert_msb (w_invert),
        .gt         (w_gt),
        .lt         (w_lt)
    );

    // Operand capture: data path only, no reset needed
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= signed_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_res   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_res   <= '0;
                        r_idx   <= IDXW'(NDIG - 1);
                        r_state <= CMP;
                    end
                end
                CMP: begin
                    // Only the first differing digit may set gt/lt
                    if (!w_found) begin
                        r_res.gt <= w_gt;
                        r_res.lt <= w_lt;
                        if (w_last && !w_gt && !w_lt)
                            r_res.eq <= 1'b1;
                    end
                    if (w_last || ((EARLY_EXIT != 0) && (w_gt || w_lt)))
                        r_state <= DONE;
                    else
                        r_idx <= r_idx - IDXW'(1);
                end
                DONE: begin
                    if (out_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign a_eq_b    = r_res.eq;
    assign a_gt_b    = r_res.gt;
    assign a_lt_b    = r_res.lt;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed and randomized checks of seq_mag_comparator across several
// DIGIT / EARLY_EXIT configurations sharing one clock and reset.
module tb_seq_mag_comparator;

    localparam int NI = 5;
    localparam int DIG_T [NI] = '{4, 4, 1, 16, 8};
    localparam int EE_T  [NI] = '{1, 0, 1, 1, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_v  [NI];
    logic        in_ready_v  [NI];
    logic [15:0] a_v         [NI];
    logic [15:0] b_v         [NI];
    logic        sm_v        [NI];
    logic        out_valid_v [NI];
    logic        out_ready_v [NI];
    logic        eq_v        [NI];
    logic        gt_v        [NI];
    logic        lt_v        [NI];
    logic        busy_v      [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        seq_mag_comparator #(
            .WIDTH      (16),
            .DIGIT      (DIG_T[gi]),
            .EARLY_EXIT (EE_T[gi])
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (in_valid_v[gi]),
            .in_ready    (in_ready_v[gi]),
            .a           (a_v[gi]),
            .b           (b_v[gi]),
            .signed_mode (sm_v[gi]),
            .out_valid   (out_valid_v[gi]),
            .out_ready   (out_ready_v[gi]),
            .a_eq_b      (eq_v[gi]),
            .a_gt_b      (gt_v[gi]),
            .a_lt_b      (lt_v[gi]),
            .busy        (busy_v[gi])
        );
    end

    // {eq, gt, lt}
    function automatic logic [2:0] model_res(input logic [15:0] av, input logic [15:0] bv,
                                             input logic sm);
        if (av == bv)                               return 3'b100;
        if (sm ? ($signed(av) > $signed(bv)) : (av > bv)) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int model_lat(input logic [15:0] av, input logic [15:0] bv,
                                     input int dig, input int ee);
        int ndig = 16 / dig;
        int mask = (1 << dig) - 1;
        if (ee == 0) return ndig;
        for (int k = ndig - 1; k >= 0; k--)
            if ((((int'(av) >> (k * dig)) ^ (int'(bv) >> (k * dig))) & mask) != 0)
                return ndig - k;
        return ndig;
    endfunction

    task automatic start_op(input int g, input logic [15:0] av, input logic [15:0] bv,
                            input logic sm);
        in_valid_v[g] = 1'b1;
        a_v[g]        = av;
        b_v[g]        = bv;
        sm_v[g]       = sm;
        @(posedge clk);
        #1;
        in_valid_v[g] = 1'b0;
        a_v[g]        = ~av;
        b_v[g]        = ~bv;
        sm_v[g]       = ~sm;
    endtask

    task automatic wait_valid(input int g, output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid_v[g]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic finish_op(input int g);
        out_ready_v[g] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[g] = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        for (int g = 0; g < NI; g++) begin
            n_tests++;
            if ({out_valid_v[g], eq_v[g], gt_v[g], lt_v[g], busy_v[g]} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got %b expected 00000", g,
                         {out_valid_v[g], eq_v[g], gt_v[g], lt_v[g], busy_v[g]});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            n_tests++;
            if ({in_ready_v[g], busy_v[g], out_valid_v[g]} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_release[%0d] rdy/busy/vld: got %b expected 100", g,
                         {in_ready_v[g], busy_v[g], out_valid_v[g]});
            end
        end
    endtask

    task automatic test_equal();
        int lat;
        start_op(0, 16'h1234, 16'h1234, 1'b0);
        n_tests++;
        if ({busy_v[0], in_ready_v[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL equal busy/in_ready: got %b expected 10", {busy_v[0], in_ready_v[0]});
        end
        wait_valid(0, lat);
        n_tests++;
        if (lat !== 4 || {eq_v[0], gt_v[0], lt_v[0]} !== 3'b100) begin
            n_fail++;
            $display("FAIL equal: lat %0d res %b expected lat 4 res 100", lat,
                     {eq_v[0], gt_v[0], lt_v[0]});
        end
        finish_op(0);
    endtask

    task automatic test_msb_diff();
        logic [15:0] ta [3];
        logic [15:0] tb [3];
        logic        ts [3];
        logic [2:0]  tr [3];
        int lat;
        ta = '{16'h8000, 16'h8000, 16'hFFFF};
        tb = '{16'h7FFF, 16'h7FFF, 16'h0000};
        ts = '{1'b0, 1'b1, 1'b1};
        tr = '{3'b010, 3'b001, 3'b001};
        for (int i = 0; i < 3; i++) begin
            start_op(0, ta[i], tb[i], ts[i]);
            wait_valid(0, lat);
            n_tests++;
            if (lat !== 1 || {eq_v[0], gt_v[0], lt_v[0]} !== tr[i]) begin
                n_fail++;
                $display("FAIL msb_diff[%0d]: lat %0d res %b expected lat 1 res %b", i, lat,
                         {eq_v[0], gt_v[0], lt_v[0]}, tr[i]);
            end
            finish_op(0);
        end
    endtask

    task automatic test_last_digit();
        int lat;
        start_op(0, 16'h0001, 16'h0002, 1'b0);
        wait_valid(0, lat);
        n_tests++;
        if (lat !== 4 || {eq_v[0], gt_v[0], lt_v[0]} !== 3'b001) begin
            n_fail++;
            $display("FAIL last_digit: lat %0d res %b expected lat 4 res 001", lat,
                     {eq_v[0], gt_v[0], lt_v[0]});
        end
        finish_op(0);
    endtask

    task automatic test_no_early_exit();
        logic [15:0] ta [2];
        logic [15:0] tb [2];
        int lat;
        ta = '{16'hF000, 16'hF000};
        tb = '{16'h0000, 16'h0FFF};
        for (int i = 0; i < 2; i++) begin
            start_op(1, ta[i], tb[i], 1'b0);
            wait_valid(1, lat);
            n_tests++;
            if (lat !== 4 || {eq_v[1], gt_v[1], lt_v[1]} !== 3'b010) begin
                n_fail++;
                $display("FAIL no_early_exit[%0d]: lat %0d res %b expected lat 4 res 010", i,
                         lat, {eq_v[1], gt_v[1], lt_v[1]});
            end
            finish_op(1);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(0, 16'h00A0, 16'h00B0, 1'b0);
        wait_valid(0, lat);
        n_tests++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL backpressure_lat: got %0d expected 3", lat);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid_v[0] = i[0] ? 1'b0 : 1'b1;
            a_v[0]        = 16'hFFFF - 16'(i);
            @(posedge clk);
            #1;
            n_tests++;
            if ({out_valid_v[0], eq_v[0], gt_v[0], lt_v[0], in_ready_v[0]} !== 5'b10010) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got %b expected 10010", i,
                         {out_valid_v[0], eq_v[0], gt_v[0], lt_v[0], in_ready_v[0]});
            end
        end
        in_valid_v[0] = 1'b0;
        finish_op(0);
        n_tests++;
        if ({in_ready_v[0], out_valid_v[0], busy_v[0]} !== 3'b100) begin
            n_fail++;
            $display("FAIL backpressure_release: got %b expected 100",
                     {in_ready_v[0], out_valid_v[0], busy_v[0]});
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        start_op(0, 16'h1111, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid_v[0], eq_v[0], gt_v[0], lt_v[0], busy_v[0]} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b expected 00000",
                     {out_valid_v[0], eq_v[0], gt_v[0], lt_v[0], busy_v[0]});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if ({in_ready_v[0], out_valid_v[0]} !== 2'b10) begin
                n_fail++;
                $display("FAIL reset_mid_idle[%0d]: rdy/vld got %b expected 10", i,
                         {in_ready_v[0], out_valid_v[0]});
            end
        end
        start_op(0, 16'h2000, 16'h1000, 1'b1);
        wait_valid(0, lat);
        n_tests++;
        if (lat !== 1 || {eq_v[0], gt_v[0], lt_v[0]} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: lat %0d res %b expected lat 1 res 010", lat,
                     {eq_v[0], gt_v[0], lt_v[0]});
        end
        finish_op(0);
    endtask

    task automatic test_back_to_back(input int g, input int n);
        logic [15:0] av, bv;
        logic        sm;
        logic [2:0]  er;
        int          el, lat, stalls;
        for (int i = 0; i < n; i++) begin
            av = 16'($urandom);
            sm = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       bv = av;
                1:       bv = av ^ (16'h1 << $urandom_range(0, 15));
                default: bv = 16'($urandom);
            endcase
            er = model_res(av, bv, sm);
            el = model_lat(av, bv, DIG_T[g], EE_T[g]);
            n_tests++;
            if (in_ready_v[g] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d.%0d]: got %b expected 1", g, i, in_ready_v[g]);
            end
            start_op(g, av, bv, sm);
            wait_valid(g, lat);
            n_tests++;
            if (lat !== el || {eq_v[g], gt_v[g], lt_v[g]} !== er) begin
                n_fail++;
                $display("FAIL b2b[%0d.%0d] a=%h b=%h s=%b: lat %0d res %b expected lat %0d res %b",
                         g, i, av, bv, sm, lat, {eq_v[g], gt_v[g], lt_v[g]}, el, er);
            end
            stalls = $urandom_range(0, 2);
            for (int s = 0; s < stalls; s++) begin
                @(posedge clk);
                #1;
                n_tests++;
                if ({out_valid_v[g], eq_v[g], gt_v[g], lt_v[g], in_ready_v[g]} !== {1'b1, er, 1'b0}) begin
                    n_fail++;
                    $display("FAIL b2b_stall[%0d.%0d]: got %b expected %b", g, i,
                             {out_valid_v[g], eq_v[g], gt_v[g], lt_v[g], in_ready_v[g]},
                             {1'b1, er, 1'b0});
                end
            end
            finish_op(g);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < NI; g++) begin
            in_valid_v[g]  = 1'b0;
            out_ready_v[g] = 1'b0;
            a_v[g]         = '0;
            b_v[g]         = '0;
            sm_v[g]        = 1'b0;
        end
        test_reset();
        test_equal();
        test_msb_diff();
        test_last_digit();
        test_no_early_exit();
        test_backpressure();
        test_reset_mid();
        fork
            test_back_to_back(0, 1000);
            test_back_to_back(1, 1000);
            test_back_to_back(2, 1000);
            test_back_to_back(3, 1000);
            test_back_to_back(4, 1000);
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mag_comparator.md
# seq_mag_comparator

Parametrised, multi-cycle magnitude comparator and successor to the team's 2-bit combinational comparator. It compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, in unsigned or two's-complement mode, with optional early exit. Results are one-hot (eq/gt/lt) and registered. Both sides use valid/ready handshakes, so the block sits between operand producers and control logic in area-constrained datapaths.

## Interface
- WIDTH, 16: operand width; must be ≥ 2.
- DIGIT, 4: bits compared per cycle; must divide WIDTH. NDIG = WIDTH/DIGIT.
- EARLY_EXIT, 1:
  - 1: finish as soon as a differing digit is found.
  - 0: always scan all NDIG digits, giving fixed latency.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- a_eq_b  out  1  A == B.
- a_gt_b  out  1  A > B.
- a_lt_b  out  1  A < B.
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture a, b and signed_mode into registers, set digit index to NDIG-1, go to CMP.
- CMP:
  - Each cycle compares captured digit slice [idx*DIGIT +: DIGIT] of A against B.
  - For idx == NDIG-1 in signed mode, invert the slice MSB of both operands (offset-binary ordering).
  - First differing digit sets the gt or lt result register.
  - EARLY_EXIT=1: on that first difference, go to DONE.
  - EARLY_EXIT=0: keep scanning; later digits never overwrite the first difference.
  - When idx == 0 with no difference found: set eq.
  - Go to DONE when idx == 0 or on early exit; otherwise decrement idx.
- DONE:
  - out_valid = 1; exactly one of eq/gt/lt is 1.
  - On out_ready, go to IDLE.
- Results and out_valid hold stable while out_valid && !out_ready.
- in_ready = 0 in CMP and DONE. in_valid is ignored there and never captured.
- Only one operation is outstanding at a time.
- Operand inputs a, b and signed_mode may change freely after capture without affecting the result.
- Result registers clear to 0 when a new operation is captured.

## Timing
- Reset (asynchronous, any state):
  - State → IDLE.
  - out_valid, a_eq_b, a_gt_b, a_lt_b, busy = 0.
  - in_ready = 1 from the first cycle after rst_n rises; in_ready is combinational from state.
  - Reset mid-CMP or mid-DONE discards the operation; no out_valid is produced.
- Latency, with capture at edge T:
  - Digit NDIG-1 is evaluated in cycle T+1.
  - A decision at digit k makes out_valid high from edge T+NDIG-k.
  - Best case T+1, when the top digit differs; worst case T+NDIG.
  - EARLY_EXIT=0: always T+NDIG.
- Output handshake: transfer at the edge where out_valid && out_ready.
  - Next cycle: IDLE with in_ready = 1.
  - Earliest next capture is one cycle after the transfer.
- Throughput: at most one compare per (latency + 2) cycles.
- Index register width: max(1, $clog2(NDIG)).
- NDIG == 1: the single CMP cycle always finishes.

## Structure
- Package cmp_pkg holds:
  - enum cmp_state_t {IDLE, CMP, DONE}.
  - struct cmp_result_t {eq, gt, lt}.
- Sub-module digit_cmp, combinational and parametrised by DIGIT:
  - Inputs: slice_a, slice_b, invert_msb.
  - Outputs: gt, lt.
  - One instance, driven by the current slice.
- Top level: FSM, operand and index registers, result registers, handshake logic.

## Test plan
(WIDTH=16, DIGIT=4 unless stated.)
- Equal operands: unsigned a=0x1234, b=0x1234 → a_eq_b=1, out_valid at T+4, other result outputs 0.
- MSB difference:
  - Unsigned a=0x8000, b=0x7FFF → a_gt_b=1 at T+1.
  - Same operands with signed_mode=1 → a_lt_b=1 at T+1.
  - Signed a=0xFFFF, b=0x0000 → a_lt_b.
- Last-digit difference: a=0x0001, b=0x0002 → a_lt_b=1 at T+4.
  - EARLY_EXIT=0 variant: a=0xF000, b=0x0000 → a_gt_b at T+4, not T+1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles after out_valid → out_valid and results stable, in_ready=0.
  - Toggle a and in_valid during that time → result unchanged and no capture.
  - Raise out_ready → IDLE next cycle.
- Reset mid-operation: assert rst_n=0 in the second CMP cycle → all outputs 0 immediately, in_ready=1 after release, no out_valid.
  - A fresh compare started afterwards is correct.
- Random back-to-back: 1000 random operands and modes, with random out_ready stalls, checked against a reference model.
  - Repeat for DIGIT=1, DIGIT=16 (NDIG=1) and DIGIT=8.
